// File: rtl/gb80_bus_arbiter.sv
// gb80_bus_arbiter: shares the external memory bus between the CPU path and
// the OAM DMA engine, one owner per 4-clock machine cycle (T0..T3).
// Optional macro ARB_ROUND_ROBIN_EN: alternate the winner when both request;
// without it the DMA always wins a tie.
//
// state   | meaning
// S_RESET | held in reset, nobody owns the bus
// S_IDLE  | machine cycle with no owner, bus parked at IDLE_ADDR
// S_CPU   | CPU owns the current machine cycle
// S_DMA   | DMA owns the current machine cycle
module gb80_bus_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] IDLE_ADDR = 16'h0000
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_cpu_req,
    input  logic                  i_cpu_wr,
    input  logic [ADDR_WIDTH-1:0] i_cpu_addr,
    input  logic [DATA_WIDTH-1:0] i_cpu_wdata,
    output logic                  o_cpu_gnt,
    output logic                  o_cpu_ack,
    output logic [DATA_WIDTH-1:0] o_cpu_rdata,
    input  logic                  i_dma_req,
    input  logic                  i_dma_wr,
    input  logic [ADDR_WIDTH-1:0] i_dma_addr,
    input  logic [DATA_WIDTH-1:0] i_dma_wdata,
    output logic                  o_dma_gnt,
    output logic                  o_dma_ack,
    output logic [DATA_WIDTH-1:0] o_dma_rdata,
    output logic                  o_mem_rd_en,
    output logic                  o_mem_wr_en,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_IDLE  = 2'd1,
        S_CPU   = 2'd2,
        S_DMA   = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [1:0]            cnt_q, cnt_d;
    logic                  wr_q, wr_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  rd_en_q, rd_en_d;
    logic                  wr_en_q, wr_en_d;
    logic                  cpu_gnt_q, cpu_gnt_d;
    logic                  cpu_ack_q, cpu_ack_d;
    logic                  dma_gnt_q, dma_gnt_d;
    logic                  dma_ack_q, dma_ack_d;
    logic [DATA_WIDTH-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_WIDTH-1:0] dma_rdata_q, dma_rdata_d;

    logic arb_edge;
    logic dma_win;
    logic cpu_win;
    logic own_d;

`ifdef ARB_ROUND_ROBIN_EN
    // last_q: 0 = CPU served last, 1 = DMA served last
    logic last_q, last_d;

    // Tie goes to whoever was not served last; a lone requester always wins.
    always_comb begin
        dma_win = i_dma_req && (!i_cpu_req || !last_q);
        cpu_win = i_cpu_req && !dma_win;
        last_d  = last_q;
        if (arb_edge && dma_win) begin
            last_d = 1'b1;
        end else if (arb_edge && cpu_win) begin
            last_d = 1'b0;
        end
    end

    // Last-served register, starts as CPU so the first tie goes to DMA.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            last_q <= 1'b0;
        end else begin
            last_q <= last_d;
        end
    end
`else
    // Fixed priority: DMA beats CPU on a tie.
    always_comb begin
        dma_win = i_dma_req;
        cpu_win = i_cpu_req && !i_dma_req;
    end
`endif

    assign arb_edge = (cnt_q == 2'd3);

    // Next owner, capture of the winner's fields, and registered bus outputs.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + 2'd1;
        wr_d        = wr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cpu_rdata_d = cpu_rdata_q;
        dma_rdata_d = dma_rdata_q;

        if (arb_edge) begin
            if (dma_win) begin
                state_d = S_DMA;
                wr_d    = i_dma_wr;
                addr_d  = i_dma_addr;
                wdata_d = i_dma_wdata;
            end else if (cpu_win) begin
                state_d = S_CPU;
                wr_d    = i_cpu_wr;
                addr_d  = i_cpu_addr;
                wdata_d = i_cpu_wdata;
            end else begin
                state_d = S_IDLE;
                wr_d    = 1'b0;
                addr_d  = IDLE_ADDR;
                wdata_d = '0;
            end
        end else if (state_q == S_RESET) begin
            state_d = S_IDLE;
        end

        // Read data is taken at the end of T2 so it is valid alongside ack in T3.
        if (cnt_q == 2'd2 && !wr_q) begin
            if (state_q == S_CPU) cpu_rdata_d = i_mem_rdata;
            if (state_q == S_DMA) dma_rdata_d = i_mem_rdata;
        end

        own_d     = (state_d == S_CPU) || (state_d == S_DMA);
        rd_en_d   = own_d && !wr_d && (cnt_d != 2'd3);
        wr_en_d   = own_d && wr_d && (cnt_d == 2'd2);
        cpu_gnt_d = (state_d == S_CPU);
        dma_gnt_d = (state_d == S_DMA);
        cpu_ack_d = cpu_gnt_d && (cnt_d == 2'd3);
        dma_ack_d = dma_gnt_d && (cnt_d == 2'd3);
    end

    // All state and outputs registered; reset abandons any cycle in flight.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= S_RESET;
            cnt_q       <= 2'b11;
            wr_q        <= 1'b0;
            addr_q      <= IDLE_ADDR;
            wdata_q     <= '0;
            rd_en_q     <= 1'b0;
            wr_en_q     <= 1'b0;
            cpu_gnt_q   <= 1'b0;
            cpu_ack_q   <= 1'b0;
            dma_gnt_q   <= 1'b0;
            dma_ack_q   <= 1'b0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rd_en_q     <= rd_en_d;
            wr_en_q     <= wr_en_d;
            cpu_gnt_q   <= cpu_gnt_d;
            cpu_ack_q   <= cpu_ack_d;
            dma_gnt_q   <= dma_gnt_d;
            dma_ack_q   <= dma_ack_d;
            cpu_rdata_q <= cpu_rdata_d;
            dma_rdata_q <= dma_rdata_d;
        end
    end

    assign o_cpu_gnt   = cpu_gnt_q;
    assign o_cpu_ack   = cpu_ack_q;
    assign o_cpu_rdata = cpu_rdata_q;
    assign o_dma_gnt   = dma_gnt_q;
    assign o_dma_ack   = dma_ack_q;
    assign o_dma_rdata = dma_rdata_q;
    assign o_mem_rd_en = rd_en_q;
    assign o_mem_wr_en = wr_en_q;
    assign o_mem_addr  = addr_q;
    assign o_mem_wdata = wdata_q;

endmodule
